uart_tx_drain: RTL and testbench



---
 rtl/uart_tx_drain_pkg.sv | 18 +
 rtl/uart_tx_drain_baud_tick.sv | 28 ++
 rtl/uart_tx_drain.sv | 142 ++++++++++++++
 tb/tb_uart_tx_drain.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the UART transmit drain: data width and FSM state encodings.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state encoding).
package uart_tx_drain_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  // 3-bit encodings kept identical to the original include file.
  typedef enum logic [2:0] {
    UART_STATE_IDLE   = 3'd0,
    UART_STATE_START  = 3'd1,
    UART_STATE_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    UART_STATE_PARITY = 3'd3,
`endif
    UART_STATE_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_drain_baud_tick.sv
// Bit-period counter: counts clock cycles within one UART bit and flags the last cycle.
// Reusable by a receiver; synchronous clear restarts the period.
module baud_tick #(
  parameter int unsigned CLOCK_DIVIDER = 12,
  parameter int unsigned DIVIDER_BITS  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [DIVIDER_BITS-1:0] LAST_COUNT = DIVIDER_BITS'(CLOCK_DIVIDER - 1);

  logic [DIVIDER_BITS-1:0] count;

  assign bit_tick = (count == LAST_COUNT);

  // Count up each cycle, wrapping at the end of a bit period or on clear.
  always_ff @(posedge clock) begin
    if (reset || clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// FIFO-draining 8N1 UART transmitter: pops a byte when idle (or at the end of a stop
// bit, for gapless streaming) and shifts it out LSB first on a registered, idle-high pin.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit between data and stop).
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDER = 12,
  parameter int unsigned DIVIDER_BITS  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fifo_ready_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_read_o,
  output logic       tx_o,
  output logic       busy_o
);

  uart_state_e state, state_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic [2:0] bit_index, bit_index_next;
  logic tx_next;
  logic bit_tick;
  logic count_clear;
`ifdef UART_TX_PARITY_EN
  logic parity, parity_next;
`endif

  // Restart the bit period on every state entry and hold it at zero while idle.
  assign count_clear = (state == UART_STATE_IDLE) || (state_next != state);
  assign busy_o      = (state != UART_STATE_IDLE);

  baud_tick #(
    .CLOCK_DIVIDER(CLOCK_DIVIDER),
    .DIVIDER_BITS (DIVIDER_BITS)
  ) u_baud_tick (
    .clock   (clock),
    .reset   (reset),
    .clear   (count_clear),
    .bit_tick(bit_tick)
  );

  // State, shift register and serial output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= UART_STATE_IDLE;
      shift     <= '0;
      bit_index <= '0;
      tx_o      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift     <= shift_next;
      bit_index <= bit_index_next;
      tx_o      <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity    <= parity_next;
`endif
    end
  end

  // Pop decision, next state and next serial bit; a pop loads the byte and starts a frame.
  always_comb begin
    state_next     = state;
    shift_next     = shift;
    bit_index_next = bit_index;
    tx_next        = tx_o;
`ifdef UART_TX_PARITY_EN
    parity_next    = parity;
`endif
    fifo_read_o = !reset && fifo_ready_i &&
                  ((state == UART_STATE_IDLE) || ((state == UART_STATE_STOP) && bit_tick));

    unique case (state)
      UART_STATE_IDLE: begin
        if (fifo_read_o) begin
          shift_next = fifo_data_i;
          state_next = UART_STATE_START;
          tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^fifo_data_i;
`endif
        end
      end
      UART_STATE_START: begin
        if (bit_tick) begin
          state_next = UART_STATE_DATA;
          tx_next    = shift[0];
          shift_next = shift >> 1;
        end
      end
      UART_STATE_DATA: begin
        if (bit_tick) begin
          if (bit_index == 3'd7) begin
            bit_index_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = UART_STATE_PARITY;
            tx_next    = parity;
`else
            state_next = UART_STATE_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_index_next = bit_index + 3'd1;
            tx_next        = shift[0];
            shift_next     = shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_STATE_PARITY: begin
        if (bit_tick) begin
          state_next = UART_STATE_STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      UART_STATE_STOP: begin
        if (bit_tick) begin
          if (fifo_read_o) begin
            shift_next = fifo_data_i;
            state_next = UART_STATE_START;
            tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo_data_i;
`endif
          end else begin
            state_next = UART_STATE_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = UART_STATE_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain: a queue-based line model checked every cycle,
// a table of single-frame vectors, and hand-written multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_drain;

  localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_ready_i = 1'b0;
  logic [7:0] fifo_data_i = '0;
  logic       fifo_read_o;
  logic       tx_o;
  logic       busy_o;

  uart_tx_drain #(.CLOCK_DIVIDER(DIV), .DIVIDER_BITS(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .fifo_ready_i(fifo_ready_i),
    .fifo_data_i (fifo_data_i),
    .fifo_read_o (fifo_read_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo_q[$];
  logic       m_q[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_pop;
  logic       read_seen = 1'b0;
  bit         mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, data, start} as sent, bit 0 first
    logic       par;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void update_ports();
    fifo_ready_i = (fifo_q.size() > 0);
    fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    update_ports();
  endtask

  // Reference line bit k of a frame, from the framing rules.
  function automatic logic model_bit(input logic [7:0] d, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Expected line bit k from a table record.
  function automatic logic tbl_bit(input logic [9:0] frame, input logic par, input int unsigned k);
    logic [3:0] kk;
    kk = 4'(k);
`ifdef UART_TX_PARITY_EN
    if (k == 9) return par;
    if (k == 10) return frame[9];
`endif
    return frame[kk];
  endfunction

  // Line model: a pop is due whenever the pending-bit queue is empty and data is waiting.
  initial forever begin
    @(negedge clock);
    if (mon_en) begin
      check("model_tx", tx_o, m_tx);
      check("model_busy", busy_o, m_busy);
      m_pop = !reset && (fifo_q.size() > 0) && (m_q.size() == 0);
      check("model_read", fifo_read_o, m_pop);
      read_seen = fifo_read_o;
      if (reset) begin
        m_q.delete();
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end else begin
        if (m_pop) begin
          for (int unsigned k = 0; k < NB; k++)
            for (int unsigned c = 0; c < DIV; c++)
              m_q.push_back(model_bit(fifo_q[0], k));
        end
        if (m_q.size() > 0) begin
          m_tx   = m_q.pop_front();
          m_busy = 1'b1;
        end else begin
          m_tx   = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  // FIFO side: remove the head after each edge where the DUT asserted read.
  initial forever begin
    @(posedge clock);
    #1;
    if (read_seen && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      update_ports();
    end
    read_seen = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_pop(input string name, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (fifo_read_o !== 1'b1 && n < limit);
    check(name, fifo_read_o, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy_o !== 1'b0 || fifo_q.size() != 0) && n < limit);
    check("wait_idle", busy_o, 1'b0);
  endtask

  // Checks every cycle of one frame; call right after the negedge of the pop cycle.
  task automatic frame_check(input string name, input logic [9:0] frame, input logic par);
    for (int unsigned k = 0; k < NB; k++)
      for (int unsigned c = 0; c < DIV; c++) begin
        @(negedge clock);
        check(name, tx_o, tbl_bit(frame, par, k));
      end
  endtask

  initial begin
    tbl[0] = '{data: 8'h00, frame: 10'b1000000000, par: 1'b0};
    tbl[1] = '{data: 8'hFF, frame: 10'b1111111110, par: 1'b0};
    tbl[2] = '{data: 8'h07, frame: 10'b1000001110, par: 1'b1};
    tbl[3] = '{data: 8'h80, frame: 10'b1100000000, par: 1'b1};
    tbl[4] = '{data: 8'hA3, frame: 10'b1101000110, par: 1'b0};
    tbl[5] = '{data: 8'h3C, frame: 10'b1001111000, par: 1'b0};

    // Reset held with data waiting: no pop, line idle.
    reset = 1'b1;
    push(8'h55);
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rst_read", fifo_read_o, 1'b0);
      check("rst_tx", tx_o, 1'b1);
      check("rst_busy", busy_o, 1'b0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single byte 0x55, busy for exactly one frame.
    wait_pop("pop_55", 10);
    frame_check("frame_55", 10'b1010101010, 1'b0);
    @(negedge clock);
    check("idle_after_55", busy_o, 1'b0);

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      wait_idle(500);
      @(posedge clock);
      #1;
      push(tbl[i].data);
      wait_pop("tbl_pop", 10);
      frame_check("tbl_frame", tbl[i].frame, tbl[i].par);
      @(negedge clock);
      check("tbl_idle", busy_o, 1'b0);
    end

    // Back-to-back frames: second pop on the last stop cycle, no idle gap.
    wait_idle(500);
    @(posedge clock);
    #1;
    push(8'hA3);
    push(8'h0F);
    wait_pop("b2b_pop1", 10);
    for (int unsigned k = 0; k < NB; k++)
      for (int unsigned c = 0; c < DIV; c++) begin
        @(negedge clock);
        check("b2b_frame1", tx_o, tbl_bit(10'b1101000110, 1'b0, k));
        if (k == NB - 1 && c == DIV - 1) check("b2b_pop2", fifo_read_o, 1'b1);
        else check("b2b_nopop", fifo_read_o, 1'b0);
      end
    frame_check("b2b_frame2", 10'b1000011110, 1'b0);
    @(negedge clock);
    check("b2b_idle", busy_o, 1'b0);

    // Empty stall: line stays high, then pop on arrival and start bit next cycle.
    repeat (7) begin
      @(negedge clock);
      check("stall_tx", tx_o, 1'b1);
      check("stall_read", fifo_read_o, 1'b0);
    end
    @(posedge clock);
    #1;
    push(8'h5A);
    @(negedge clock);
    check("stall_pop", fifo_read_o, 1'b1);
    @(negedge clock);
    check("stall_start", tx_o, 1'b0);
    wait_idle(500);

    // Reset during data bit 3 of 0xFF with the next byte waiting.
    @(posedge clock);
    #1;
    push(8'hFF);
    wait_pop("mid_pop", 10);
    @(posedge clock);
    repeat (4 * DIV + 1) @(posedge clock);
    #1;
    push(8'h3C);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_noread", fifo_read_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_tx", tx_o, 1'b1);
    check("mid_rst_idle", busy_o, 1'b0);
    check("mid_rst_pop", fifo_read_o, 1'b1);
    frame_check("mid_rst_next", 10'b1001111000, 1'b0);
    wait_idle(500);

    // Random traffic and occasional resets against the line model.
    for (int i = 0; i < 600; i++) begin
      @(posedge clock);
      #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 149) == 0) reset = 1'b1;
      if ($urandom_range(0, 5) == 0 && fifo_q.size() < 3) push(8'($urandom));
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_idle(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
